// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types, defaults and helpers for the game command sequencer
//   ctrl_mode_e : count-mode codes driven on control
//   seq_state_e : sequencer FSM states
//   game_cmd_t  : one queued command {load, init, mode, len}
package game_pkg;

  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned DEF_RST_CYCLES = 2;

  typedef enum logic [1:0] {
    UP1 = 2'b00,
    UP2 = 2'b01,
    DN1 = 2'b10,
    DN2 = 2'b11
  } ctrl_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    RESTART
  } seq_state_e;

  typedef struct packed {
    logic       load;
    logic [3:0] init;
    ctrl_mode_e mode;
    logic [7:0] len;
  } game_cmd_t;

  // RUN counts down to zero, so it is loaded with cycles-1; len=0 behaves as len=1.
  function automatic logic [7:0] run_cycles_m1(input logic [7:0] len);
    return (len == 8'd0) ? 8'd0 : len - 8'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/game_cmd_seq_if.sv
// rtl/game_cmd_seq_if.sv - command push bus between a command source and the sequencer
//   cmd_valid/cmd_ready : push handshake
//   cmd_load/cmd_init/cmd_mode/cmd_len : command fields
interface game_cmd_seq_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [3:0] cmd_init;
  logic [1:0] cmd_mode;
  logic [7:0] cmd_len;

  modport master (
    output cmd_valid, cmd_load, cmd_init, cmd_mode, cmd_len,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_load, cmd_init, cmd_mode, cmd_len,
    output cmd_ready
  );

endinterface

// File: rtl/game_cmd_fifo.sv
// rtl/game_cmd_fifo.sv - synchronous command FIFO with registered full/empty
//   clk, reset : clock, synchronous active-high reset
//   push/wdata : write when push and not full
//   pop/rdata  : rdata is the head; advanced when pop and not empty
//   full/empty : registered occupancy flags
module game_cmd_fifo
  import game_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  game_cmd_t wdata,
  input  logic      pop,
  output game_cmd_t rdata,
  output logic      full,
  output logic      empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          push_fire, pop_fire;
  game_cmd_t     mem_q [DEPTH];
  game_cmd_t     mem_d [DEPTH];

  always_comb begin
    push_fire = push && !full_q;
    pop_fire  = pop && !empty_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push_fire) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_fire) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    // Simultaneous push and pop leaves occupancy unchanged.
    case ({push_fire, pop_fire})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH_W);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/game_cmd_seq.sv
// rtl/game_cmd_seq.sv - queues commands and sequences load/mode/restart to a game counter
//   clk, reset   : clock, synchronous active-high reset
//   cmd          : command push bus (slave side)
//   GAMEOVER     : game-over flag from the game counter
//   INIT_c/INIT_l: load strobe and load value
//   control      : count-mode code
//   game_reset   : game counter reset pulse
//   busy         : sequencer active or commands queued
//   gameover_cnt : saturating count of game-over restarts
module game_cmd_seq
  import game_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned RST_CYCLES = DEF_RST_CYCLES
) (
  input  logic          clk,
  input  logic          reset,
  game_cmd_seq_if.slave cmd,
  input  logic          GAMEOVER,
  output logic          INIT_c,
  output logic [3:0]    INIT_l,
  output logic [1:0]    control,
  output logic          game_reset,
  output logic          busy,
  output logic [7:0]    gameover_cnt
);

  localparam int unsigned   RCW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);

  seq_state_e     state_q, state_d;
  ctrl_mode_e     cur_mode_q, cur_mode_d;
  logic [7:0]     run_cnt_q, run_cnt_d;
  logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
  logic           init_c_q, init_c_d;
  logic [3:0]     init_l_q, init_l_d;
  ctrl_mode_e     control_q, control_d;
  logic           game_reset_q, game_reset_d;
  logic           busy_q, busy_d;
  logic [7:0]     go_cnt_q, go_cnt_d;

  game_cmd_t      fifo_wdata, fifo_head;
  logic           fifo_full, fifo_empty, fifo_pop;
  logic           push_fire, go_restart;

  always_comb begin
    fifo_wdata.load = cmd.cmd_load;
    fifo_wdata.init = cmd.cmd_init;
    fifo_wdata.mode = ctrl_mode_e'(cmd.cmd_mode);
    fifo_wdata.len  = cmd.cmd_len;
  end

  game_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd.cmd_valid),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cmd.cmd_ready = !fifo_full;
  assign push_fire     = cmd.cmd_valid && !fifo_full;

  always_comb begin
    state_d      = state_q;
    cur_mode_d   = cur_mode_q;
    run_cnt_d    = run_cnt_q;
    rst_cnt_d    = rst_cnt_q;
    init_c_d     = 1'b0;
    init_l_d     = init_l_q;
    control_d    = control_q;
    game_reset_d = 1'b0;
    go_cnt_d     = go_cnt_q;
    fifo_pop     = 1'b0;

    // Game-over wins over any pop/load/run step this cycle; RESTART ignores it.
    go_restart = GAMEOVER && (state_q != RESTART);

    if (go_restart) begin
      state_d      = RESTART;
      game_reset_d = 1'b1;
      rst_cnt_d    = RST_LAST;
      go_cnt_d     = sat_inc8(go_cnt_q);
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            cur_mode_d = fifo_head.mode;
            run_cnt_d  = run_cycles_m1(fifo_head.len);
            if (fifo_head.load) begin
              state_d  = LOAD;
              init_c_d = 1'b1;
              init_l_d = fifo_head.init;
            end else begin
              state_d   = RUN;
              control_d = fifo_head.mode;
            end
          end
        end
        LOAD: begin
          state_d   = RUN;
          control_d = cur_mode_q;
        end
        RUN: begin
          if (run_cnt_q == 8'd0) begin
            state_d = IDLE;
          end else begin
            run_cnt_d = run_cnt_q - 8'd1;
          end
        end
        RESTART: begin
          if (rst_cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            game_reset_d = 1'b1;
            rst_cnt_d    = rst_cnt_q - RCW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A pop always leaves IDLE, so next-cycle emptiness only matters without one.
    busy_d = (state_d != IDLE) || !fifo_empty || push_fire;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cur_mode_q   <= UP1;
      run_cnt_q    <= '0;
      rst_cnt_q    <= '0;
      init_c_q     <= 1'b0;
      init_l_q     <= '0;
      control_q    <= UP1;
      game_reset_q <= 1'b0;
      busy_q       <= 1'b0;
      go_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      cur_mode_q   <= cur_mode_d;
      run_cnt_q    <= run_cnt_d;
      rst_cnt_q    <= rst_cnt_d;
      init_c_q     <= init_c_d;
      init_l_q     <= init_l_d;
      control_q    <= control_d;
      game_reset_q <= game_reset_d;
      busy_q       <= busy_d;
      go_cnt_q     <= go_cnt_d;
    end
  end

  assign INIT_c       = init_c_q;
  assign INIT_l       = init_l_q;
  assign control      = control_q;
  assign game_reset   = game_reset_q;
  assign busy         = busy_q;
  assign gameover_cnt = go_cnt_q;

endmodule

// File: tb/tb_game_cmd_seq.sv
// tb/tb_game_cmd_seq.sv - directed self-checking bench for game_cmd_seq
module tb_game_cmd_seq;

  logic       clk;
  logic       reset;
  logic       GAMEOVER;
  logic       INIT_c;
  logic [3:0] INIT_l;
  logic [1:0] control;
  logic       game_reset;
  logic       busy;
  logic [7:0] gameover_cnt;

  int errors = 0;
  int checks = 0;

  game_cmd_seq_if cmd_if ();

  game_cmd_seq #(
    .FIFO_DEPTH (4),
    .RST_CYCLES (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd          (cmd_if),
    .GAMEOVER     (GAMEOVER),
    .INIT_c       (INIT_c),
    .INIT_l       (INIT_l),
    .control      (control),
    .game_reset   (game_reset),
    .busy         (busy),
    .gameover_cnt (gameover_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_cmd(input logic ld, input logic [3:0] ini, input logic [1:0] md, input logic [7:0] ln);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_load  = ld;
    cmd_if.cmd_init  = ini;
    cmd_if.cmd_mode  = md;
    cmd_if.cmd_len   = ln;
  endtask

  initial begin
    reset            = 1'b1;
    GAMEOVER         = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_load  = 1'b0;
    cmd_if.cmd_init  = 4'h0;
    cmd_if.cmd_mode  = 2'b00;
    cmd_if.cmd_len   = 8'd0;

    // Reset state
    tick();
    tick();
    chk("rst_init_c", 32'(INIT_c), 32'd0);
    chk("rst_init_l", 32'(INIT_l), 32'd0);
    chk("rst_control", 32'(control), 32'd0);
    chk("rst_game_reset", 32'(game_reset), 32'd0);
    chk("rst_gameover_cnt", 32'(gameover_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_if.cmd_ready), 32'd1);
    reset = 1'b0;
    tick();

    // Load command: INIT_c pulse then 3 RUN cycles of mode 10
    set_cmd(1'b1, 4'b1000, 2'b10, 8'd3);
    tick();
    cmd_if.cmd_valid = 1'b0;
    chk("t1_busy_after_push", 32'(busy), 32'd1);
    chk("t1_no_early_init_c", 32'(INIT_c), 32'd0);
    tick();
    chk("t1_init_c", 32'(INIT_c), 32'd1);
    chk("t1_init_l", 32'(INIT_l), 32'h8);
    chk("t1_control_in_load", 32'(control), 32'd0);
    tick();
    chk("t1_init_c_drop", 32'(INIT_c), 32'd0);
    chk("t1_control_run", 32'(control), 32'd2);
    tick();
    tick();
    chk("t1_busy_last_run", 32'(busy), 32'd1);
    tick();
    chk("t1_busy_done", 32'(busy), 32'd0);
    chk("t1_control_hold", 32'(control), 32'd2);
    chk("t1_init_l_hold", 32'(INIT_l), 32'h8);

    // len=0 behaves as one cycle
    set_cmd(1'b0, 4'h0, 2'b01, 8'd0);
    tick();
    cmd_if.cmd_valid = 1'b0;
    tick();
    chk("t2_control", 32'(control), 32'd1);
    chk("t2_busy_run", 32'(busy), 32'd1);
    tick();
    chk("t2_busy_done", 32'(busy), 32'd0);

    // FIFO full: long command occupies the FSM while 5 commands are offered
    set_cmd(1'b0, 4'h0, 2'b00, 8'd8);
    tick();
    cmd_if.cmd_valid = 1'b0;
    tick();
    set_cmd(1'b0, 4'h0, 2'b01, 8'd1);
    tick();
    set_cmd(1'b0, 4'h0, 2'b10, 8'd1);
    tick();
    set_cmd(1'b0, 4'h0, 2'b11, 8'd1);
    tick();
    set_cmd(1'b0, 4'h0, 2'b00, 8'd1);
    tick();
    chk("t3_ready_full", 32'(cmd_if.cmd_ready), 32'd0);
    set_cmd(1'b1, 4'hA, 2'b11, 8'd1);
    repeat (4) tick();
    chk("t3_ready_held", 32'(cmd_if.cmd_ready), 32'd0);
    chk("t3_busy_held", 32'(busy), 32'd1);
    tick();
    chk("t3_ready_after_pop", 32'(cmd_if.cmd_ready), 32'd1);
    chk("t3_cmd1_control", 32'(control), 32'd1);
    tick();
    cmd_if.cmd_valid = 1'b0;
    chk("t3_ready_refull", 32'(cmd_if.cmd_ready), 32'd0);
    tick();
    chk("t3_cmd2_control", 32'(control), 32'd2);
    tick();
    tick();
    chk("t3_cmd3_control", 32'(control), 32'd3);
    tick();
    tick();
    chk("t3_cmd4_control", 32'(control), 32'd0);
    tick();
    tick();
    chk("t3_cmd5_init_c", 32'(INIT_c), 32'd1);
    chk("t3_cmd5_init_l", 32'(INIT_l), 32'hA);
    tick();
    chk("t3_cmd5_control", 32'(control), 32'd3);
    tick();
    chk("t3_busy_done", 32'(busy), 32'd0);

    // GAMEOVER in 2nd RUN cycle of a len=10 command, held into RESTART
    set_cmd(1'b0, 4'h0, 2'b10, 8'd10);
    tick();
    set_cmd(1'b0, 4'h0, 2'b01, 8'd1);
    tick();
    cmd_if.cmd_valid = 1'b0;
    tick();
    GAMEOVER = 1'b1;
    tick();
    chk("t4_game_reset_1", 32'(game_reset), 32'd1);
    chk("t4_gameover_cnt", 32'(gameover_cnt), 32'd1);
    chk("t4_control_hold", 32'(control), 32'd2);
    tick();
    chk("t4_game_reset_2", 32'(game_reset), 32'd1);
    chk("t4_gameover_ignored", 32'(gameover_cnt), 32'd1);
    GAMEOVER = 1'b0;
    tick();
    chk("t4_game_reset_end", 32'(game_reset), 32'd0);
    chk("t4_busy_queued", 32'(busy), 32'd1);
    tick();
    chk("t4_next_entry", 32'(control), 32'd1);
    tick();
    chk("t4_busy_done", 32'(busy), 32'd0);

    // GAMEOVER on the edge that would start LOAD: no INIT_c, no pop
    set_cmd(1'b1, 4'h5, 2'b11, 8'd1);
    tick();
    cmd_if.cmd_valid = 1'b0;
    GAMEOVER = 1'b1;
    tick();
    chk("t5_no_init_c", 32'(INIT_c), 32'd0);
    chk("t5_game_reset", 32'(game_reset), 32'd1);
    chk("t5_gameover_cnt", 32'(gameover_cnt), 32'd2);
    GAMEOVER = 1'b0;
    tick();
    tick();
    chk("t5_restart_end", 32'(game_reset), 32'd0);
    chk("t5_busy_retained", 32'(busy), 32'd1);
    tick();
    chk("t5_init_c_later", 32'(INIT_c), 32'd1);
    chk("t5_init_l_later", 32'(INIT_l), 32'h5);
    tick();
    chk("t5_control", 32'(control), 32'd3);
    tick();
    chk("t5_busy_done", 32'(busy), 32'd0);

    // Reset mid-RUN with 2 entries queued
    set_cmd(1'b0, 4'h0, 2'b01, 8'd10);
    tick();
    set_cmd(1'b0, 4'h0, 2'b10, 8'd1);
    tick();
    set_cmd(1'b0, 4'h0, 2'b11, 8'd1);
    tick();
    cmd_if.cmd_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("t6_init_c", 32'(INIT_c), 32'd0);
    chk("t6_init_l", 32'(INIT_l), 32'd0);
    chk("t6_control", 32'(control), 32'd0);
    chk("t6_game_reset", 32'(game_reset), 32'd0);
    chk("t6_gameover_cnt", 32'(gameover_cnt), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_cmd_ready", 32'(cmd_if.cmd_ready), 32'd1);
    reset = 1'b0;
    tick();
    tick();
    chk("t6_fifo_flushed_busy", 32'(busy), 32'd0);
    chk("t6_fifo_flushed_control", 32'(control), 32'd0);

    // Saturation: GAMEOVER held restarts every 3 cycles
    GAMEOVER = 1'b1;
    tick();
    chk("t7_cnt_1", 32'(gameover_cnt), 32'd1);
    repeat (253) repeat (3) tick();
    chk("t7_cnt_254", 32'(gameover_cnt), 32'd254);
    repeat (3) tick();
    chk("t7_cnt_255", 32'(gameover_cnt), 32'd255);
    repeat (3) tick();
    chk("t7_cnt_sat_256", 32'(gameover_cnt), 32'd255);
    repeat (30) tick();
    chk("t7_cnt_sat_hold", 32'(gameover_cnt), 32'd255);
    GAMEOVER = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
